// File: rtl/kbd_event_matrix.sv
// kbd_event_matrix: active-low keyboard matrix for the PET clone.
// The MCU writes columns directly over Wishbone, or queues press/release
// events that are applied one at a time. After each event the sequencer
// waits for HOLD_SCANS keyboard scans, so the CPU sees every change.
module kbd_event_matrix #(
    parameter int COL_COUNT     = 10,
    parameter int ROW_COUNT     = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int HOLD_DEFAULT  = 2,
    parameter int COL_SEL_WIDTH = 4
) (
    input  logic                                wb_clock_i,
    input  logic                                wb_reset_i,
    input  logic [4:0]                          wb_addr_i,
    input  logic [7:0]                          wb_data_i,
    output logic [7:0]                          wb_data_o,
    input  logic                                wb_we_i,
    input  logic                                wb_cycle_i,
    input  logic                                wb_strobe_i,
    input  logic                                wb_sel_i,
    output logic                                wb_stall_o,
    output logic                                wb_ack_o,
    input  logic [COL_SEL_WIDTH-1:0]            col_sel_i,
    input  logic                                col_sel_we_i,
    output logic [COL_COUNT-1:0][ROW_COUNT-1:0] kbd_o
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [4:0]    LP_COLS  = 5'(COL_COUNT);
    localparam logic [3:0]    LP_ROWS  = 4'(ROW_COUNT);
    localparam logic [CW-1:0] LP_DEPTH = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_HOLD} state_t;

    // Registers
    state_t               r_state;
    logic [ROW_COUNT-1:0] r_cols [COL_COUNT];
    logic [7:0]           r_fifo [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_ovf;
    logic [7:0]           r_hold;
    logic                 r_pause;
    logic [7:0]           r_evt;
    logic [7:0]           r_scan_cnt;
    logic                 r_ack;
    logic [7:0]           r_rdata;

    // Combinational signals
    state_t               w_state_next;
    logic                 w_req, w_acc, w_wr;
    logic                 w_col_wr, w_evt_wr, w_stat_wr, w_hold_wr, w_ctrl_wr;
    logic                 w_flush, w_push, w_push_ok, w_pop;
    logic                 w_full, w_empty;
    logic [7:0]           w_head;
    logic [7:0]           w_evt;
    logic                 w_try;
    logic [3:0]           w_evt_col;
    logic [2:0]           w_evt_row;
    logic                 w_evt_ok;
    logic                 w_col_busy;
    logic                 w_do_apply;
    logic [ROW_COUNT-1:0] w_row_mask;
    logic [7:0]           w_rd_data;
    logic                 w_scan;

    // Bus decode; an access with wb_sel_i low is acked but has no effect.
    assign w_req     = wb_cycle_i && wb_strobe_i;
    assign w_acc     = w_req && wb_sel_i;
    assign w_wr      = w_acc && wb_we_i;
    assign w_col_wr  = w_wr && !wb_addr_i[4] && ({1'b0, wb_addr_i[3:0]} < LP_COLS);
    assign w_evt_wr  = w_wr && (wb_addr_i == 5'h10);
    assign w_stat_wr = w_wr && (wb_addr_i == 5'h11);
    assign w_hold_wr = w_wr && (wb_addr_i == 5'h12);
    assign w_ctrl_wr = w_wr && (wb_addr_i == 5'h13);
    assign w_flush   = w_ctrl_wr && wb_data_i[1];
    assign w_push    = w_evt_wr;

    assign w_full    = (r_count == LP_DEPTH);
    assign w_empty   = (r_count == '0);
    // A push into a full FIFO is still accepted if a pop frees a slot in the same cycle.
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_head    = r_fifo[r_rd_ptr];

    // A scan starts whenever the CPU selects column 0.
    assign w_scan    = col_sel_we_i && (col_sel_i == '0);

    // Event being applied: the FIFO head on a pop, or the stalled event in APPLY.
    assign w_evt_col  = w_evt[6:3];
    assign w_evt_row  = w_evt[2:0];
    assign w_evt_ok   = ({1'b0, w_evt_col} < LP_COLS) && ({1'b0, w_evt_row} < LP_ROWS);
    assign w_col_busy = w_col_wr && (wb_addr_i[3:0] == w_evt_col);
    assign w_do_apply = w_try && w_evt_ok && !w_col_busy;

    // Sequencer state register.
    always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
        if (wb_reset_i) r_state <= S_IDLE;
        else            r_state <= w_state_next;
    end

    // Sequencer next state: a popped event is applied on the pop cycle unless a
    // direct write to the same column wins; then APPLY retries it next cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    if (!w_evt_ok)       w_state_next = S_IDLE;
                    else if (w_col_busy) w_state_next = S_APPLY;
                    else                 w_state_next = S_HOLD;
                end
            end
            S_APPLY: if (!w_col_busy) w_state_next = S_HOLD;
            S_HOLD:  if (r_scan_cnt >= r_hold) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Sequencer outputs: pop request and the event presented to the apply logic.
    always_comb begin
        w_pop = 1'b0;
        w_evt = r_evt;
        w_try = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pop = !w_empty && !r_pause;
                w_evt = w_head;
                w_try = !w_empty && !r_pause;
            end
            S_APPLY: w_try = 1'b1;
            default: ;
        endcase
    end

    // One-hot row mask of the event's row.
    always_comb begin
        w_row_mask = '0;
        for (int i = 0; i < ROW_COUNT; i++) w_row_mask[i] = (w_evt_row == 3'(i));
    end

    // Per-column storage: a direct write takes priority over an event apply.
    for (genvar gi = 0; gi < COL_COUNT; gi++) begin : g_col
        // Column gi register, released (all ones) on reset.
        always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
            if (wb_reset_i)
                r_cols[gi] <= '1;
            else if (w_col_wr && (wb_addr_i[3:0] == 4'(gi)))
                r_cols[gi] <= wb_data_i[ROW_COUNT-1:0];
            else if (w_do_apply && (w_evt_col == 4'(gi)))
                r_cols[gi] <= w_evt[7] ? (r_cols[gi] | w_row_mask) : (r_cols[gi] & ~w_row_mask);
        end
        assign kbd_o[gi] = r_cols[gi];
    end

    // Event FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge wb_clock_i) begin
        if (w_push_ok) r_fifo[r_wr_ptr] <= wb_data_i;
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_flush) begin
                r_rd_ptr <= r_wr_ptr;
                r_count  <= '0;
            end else begin
                if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
                if (w_push_ok && !w_pop)      r_count <= r_count + CW'(1);
                else if (!w_push_ok && w_pop) r_count <= r_count - CW'(1);
            end
            if (w_push && !w_push_ok)          r_ovf <= 1'b1;
            else if (w_stat_wr && wb_data_i[7]) r_ovf <= 1'b0;
        end
    end

    // Latched event, hold-scan counter and control registers.
    always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            r_evt      <= 8'h00;
            r_scan_cnt <= 8'h00;
            r_hold     <= 8'(HOLD_DEFAULT);
            r_pause    <= 1'b0;
        end else begin
            if (w_pop) r_evt <= w_head;
            // A scan in the apply cycle itself is not counted.
            if (w_do_apply)
                r_scan_cnt <= 8'h00;
            else if ((r_state == S_HOLD) && w_scan && (r_scan_cnt != 8'hFF))
                r_scan_cnt <= r_scan_cnt + 8'd1;
            if (w_hold_wr) r_hold  <= wb_data_i;
            if (w_ctrl_wr) r_pause <= wb_data_i[0];
        end
    end

    // Read data multiplexer.
    always_comb begin
        w_rd_data = 8'h00;
        if (!wb_addr_i[4]) begin
            // Unimplemented columns and rows read as released.
            w_rd_data = 8'hFF;
            for (int c = 0; c < COL_COUNT; c++)
                if (wb_addr_i[3:0] == 4'(c)) w_rd_data[ROW_COUNT-1:0] = r_cols[c];
        end else begin
            case (wb_addr_i[3:0])
                4'h1:    w_rd_data = {r_ovf, w_full, 6'(r_count)};
                4'h2:    w_rd_data = r_hold;
                4'h3:    w_rd_data = {7'd0, r_pause};
                default: w_rd_data = 8'h00;
            endcase
        end
    end

    // Bus response: one ack per strobe, read data registered alongside it.
    always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            r_ack   <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            r_ack   <= w_req;
            r_rdata <= (w_acc && !wb_we_i) ? w_rd_data : 8'h00;
        end
    end

    assign wb_ack_o   = r_ack;
    assign wb_data_o  = r_rdata;
    assign wb_stall_o = 1'b0;

endmodule

// File: tb/tb_kbd_event_matrix.sv
// Testbench for kbd_event_matrix: register table, hand-written timing
// sequences and randomized event batches against a queue-based model.
module tb_kbd_event_matrix;
    localparam int NC    = 10;
    localparam int NR    = 8;
    localparam int DEPTH = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [4:0]             addr = '0;
    logic [7:0]             wdata = '0;
    logic [7:0]             rdata;
    logic                   we = 1'b0, cyc = 1'b0, stb = 1'b0, sel = 1'b0;
    logic                   stall, ack;
    logic [3:0]             col_sel = 4'hF;
    logic                   col_sel_we = 1'b0;
    logic [NC-1:0][NR-1:0]  kbd;

    int total = 0;
    int bad   = 0;
    logic [7:0] mdl [NC];

    typedef struct {
        logic [4:0] a;
        logic       w;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [20];

    kbd_event_matrix dut (
        .wb_clock_i  (clk),
        .wb_reset_i  (rst),
        .wb_addr_i   (addr),
        .wb_data_i   (wdata),
        .wb_data_o   (rdata),
        .wb_we_i     (we),
        .wb_cycle_i  (cyc),
        .wb_strobe_i (stb),
        .wb_sel_i    (sel),
        .wb_stall_o  (stall),
        .wb_ack_o    (ack),
        .col_sel_i   (col_sel),
        .col_sel_we_i(col_sel_we),
        .kbd_o       (kbd)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic wb_xfer(input logic [4:0] a, input logic [7:0] d, input logic w,
                           input logic s, output logic [7:0] r);
        @(negedge clk);
        addr = a; wdata = d; we = w; sel = s; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 1'b0;
        r = rdata;
        check($sformatf("ack a=%0h", a), ack, 1'b1);
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        logic [7:0] r;
        wb_xfer(a, d, 1'b1, 1'b1, r);
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string name);
        logic [7:0] r;
        wb_xfer(a, 8'h00, 1'b0, 1'b1, r);
        check(name, r, exp);
    endtask

    task automatic scan(input logic [3:0] v);
        @(negedge clk);
        col_sel = v; col_sel_we = 1'b1;
        @(posedge clk);
        #1;
        col_sel_we = 1'b0; col_sel = 4'hF;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] r8;
        logic [7:0] ev;
        logic [7:0] q[$];
        int n, c, rr, h, a;
        logic ovf;

        // Register vectors: {address, write, data, expected read}
        tbl[0]  = '{5'h00, 1'b0, 8'h00, 8'hFF};
        tbl[1]  = '{5'h09, 1'b0, 8'h00, 8'hFF};
        tbl[2]  = '{5'h0A, 1'b0, 8'h00, 8'hFF};
        tbl[3]  = '{5'h0F, 1'b0, 8'h00, 8'hFF};
        tbl[4]  = '{5'h10, 1'b0, 8'h00, 8'h00};
        tbl[5]  = '{5'h11, 1'b0, 8'h00, 8'h00};
        tbl[6]  = '{5'h12, 1'b0, 8'h00, 8'h02};
        tbl[7]  = '{5'h13, 1'b0, 8'h00, 8'h00};
        tbl[8]  = '{5'h1F, 1'b0, 8'h00, 8'h00};
        tbl[9]  = '{5'h02, 1'b1, 8'h5A, 8'h00};
        tbl[10] = '{5'h02, 1'b0, 8'h00, 8'h5A};
        tbl[11] = '{5'h0C, 1'b1, 8'h00, 8'h00};
        tbl[12] = '{5'h0C, 1'b0, 8'h00, 8'hFF};
        tbl[13] = '{5'h12, 1'b1, 8'h07, 8'h00};
        tbl[14] = '{5'h12, 1'b0, 8'h00, 8'h07};
        tbl[15] = '{5'h13, 1'b1, 8'h02, 8'h00};
        tbl[16] = '{5'h13, 1'b0, 8'h00, 8'h00};
        tbl[17] = '{5'h1E, 1'b1, 8'h55, 8'h00};
        tbl[18] = '{5'h1E, 1'b0, 8'h00, 8'h00};
        tbl[19] = '{5'h02, 1'b1, 8'hFF, 8'h00};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset ack", ack, 1'b0);
        check("reset data", rdata, 8'h00);
        check("reset kbd", kbd, {NC*NR{1'b1}});
        check("stall", stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven register accesses
        for (int i = 0; i < 20; i++) begin
            if (tbl[i].w) wr(tbl[i].a, tbl[i].d);
            else          rd(tbl[i].a, tbl[i].exp, $sformatf("tbl[%0d] rd %0h", i, tbl[i].a));
        end
        idle(1);
        check("ack drops when idle", ack, 1'b0);

        // Byte select low: acked, no effect
        wb_xfer(5'h00, 8'h00, 1'b1, 1'b0, r8);
        check("sel=0 write ignored", kbd[0], 8'hFF);

        // Direct column writes, read back over the bus and on kbd_o
        for (int i = 0; i < NC; i++) wr(5'(i), 8'(8'h50 + i));
        for (int i = 0; i < NC; i++) begin
            rd(5'(i), 8'(8'h50 + i), $sformatf("col %0d rd", i));
            check($sformatf("col %0d kbd", i), kbd[i], 8'(8'h50 + i));
        end
        for (int i = 0; i < NC; i++) wr(5'(i), 8'hFF);
        idle(1);
        check("all released", kbd, {NC*NR{1'b1}});

        // Press then release col 3 row 5 with HOLD_SCANS = 2
        wr(5'h12, 8'd2);
        wr(5'h10, 8'h1D);
        check("press not yet", kbd[3][5], 1'b1);
        wr(5'h10, 8'h9D);
        check("press at push+2", kbd[3][5], 1'b0);
        idle(3);
        scan(4'h3);
        scan(4'h0);
        idle(4);
        check("held after 1 scan", kbd[3][5], 1'b0);
        scan(4'h0);
        check("held at 2nd scan", kbd[3][5], 1'b0);
        idle(1);
        check("held at scan+1", kbd[3][5], 1'b0);
        idle(1);
        check("released at scan+2", kbd[3][5], 1'b1);
        scan(4'h0);
        scan(4'h0);
        idle(2);
        rd(5'h11, 8'h00, "fifo empty after pair");

        // Overflow, clear, flush
        wr(5'h13, 8'h01);
        for (int i = 0; i < DEPTH + 1; i++) wr(5'h10, 8'(i));
        rd(5'h11, 8'hC8, "status overflow full");
        wr(5'h11, 8'h80);
        rd(5'h11, 8'h48, "status ovf cleared");
        wr(5'h13, 8'h03);
        rd(5'h11, 8'h00, "status flushed");
        rd(5'h13, 8'h01, "ctrl flush self-clears");
        for (int i = 0; i < DEPTH + 1; i++) wr(5'h10, 8'(i));
        wr(5'h13, 8'h03);
        rd(5'h11, 8'h80, "flush keeps overflow");
        wr(5'h11, 8'h80);
        wr(5'h12, 8'd0);
        wr(5'h13, 8'h00);
        idle(6);
        check("flushed events not applied", kbd, {NC*NR{1'b1}});

        // Event and direct write hit the same column in the same cycle
        wr(5'h10, 8'h21);
        wr(5'h04, 8'h0F);
        check("direct write wins", kbd[4], 8'h0F);
        idle(1);
        check("event applied next cycle", kbd[4], 8'h0D);
        rd(5'h04, 8'h0D, "col 4 after collision");
        wr(5'h04, 8'hFF);

        // Reset during HOLD with three events queued
        wr(5'h12, 8'd2);
        wr(5'h10, 8'h28);
        wr(5'h10, 8'h29);
        wr(5'h10, 8'h2A);
        wr(5'h10, 8'h2B);
        rd(5'h11, 8'h03, "three queued");
        check("first event held", kbd[5], 8'hFE);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async reset kbd", kbd, {NC*NR{1'b1}});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd(5'h11, 8'h00, "status after reset");
        rd(5'h12, 8'h02, "hold after reset");
        for (int i = 0; i < 4; i++) begin scan(4'h0); idle(2); end
        check("nothing applies after reset", kbd, {NC*NR{1'b1}});

        // Randomized batches against a queue model
        for (int i = 0; i < NC; i++) mdl[i] = 8'hFF;
        for (int rnd = 0; rnd < 6; rnd++) begin
            for (int k = 0; k < 4; k++) begin
                a  = $urandom_range(0, 15);
                r8 = 8'($urandom);
                wr(5'(a), r8);
                if (a < NC) mdl[a] = r8;
            end
            h = $urandom_range(0, 3);
            wr(5'h12, 8'(h));
            wr(5'h13, 8'h01);
            n = $urandom_range(1, 10);
            q.delete();
            for (int k = 0; k < n; k++) begin
                ev = 8'($urandom);
                wr(5'h10, ev);
                if (q.size() < DEPTH) q.push_back(ev);
            end
            ovf = (n > DEPTH);
            rd(5'h11, {ovf, (q.size() == DEPTH), 6'(q.size())}, $sformatf("rnd%0d status n=%0d", rnd, n));
            if (ovf) wr(5'h11, 8'h80);
            wr(5'h13, 8'h00);
            for (int it = 0; it < 60; it++) begin scan(4'h0); idle(3); end
            foreach (q[k]) begin
                c  = int'(q[k][6:3]);
                rr = int'(q[k][2:0]);
                if (c < NC && rr < NR) mdl[c][rr] = q[k][7];
            end
            rd(5'h11, 8'h00, $sformatf("rnd%0d drained", rnd));
            for (int i = 0; i < NC; i++)
                check($sformatf("rnd%0d kbd col %0d", rnd, i), kbd[i], mdl[i]);
            a = $urandom_range(0, NC - 1);
            rd(5'(a), mdl[a], $sformatf("rnd%0d rd col %0d", rnd, a));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/kbd_event_matrix.md
# kbd_event_matrix

Parametrised keyboard matrix for the PET clone. It holds a COL_COUNT × ROW_COUNT active-low key matrix that the MCU can access over Wishbone, either by writing columns directly or by pushing key events into a FIFO. Queued events are applied one at a time and paced against the CPU's keyboard scan, so every press and release stays visible for at least HOLD_SCANS full scans. Its output drives the io block's PIA keyboard input in place of the plain column register file.

## Interface
- COL_COUNT, 10: number of columns, 1..16.
- ROW_COUNT, 8: rows per column, 1..8.
- FIFO_DEPTH, 8: event FIFO entries, power of 2, 2..64.
- HOLD_DEFAULT, 2: reset value of HOLD_SCANS, 0..255.
- COL_SEL_WIDTH, 4: width of the CPU column select.

- wb_clock_i  in  1  system clock.
- wb_reset_i  in  1  reset, asynchronous and active-high.
- wb_addr_i  in  5  register address.
- wb_data_i  in  8  write data.
- wb_data_o  out  8  read data.
- wb_we_i  in  1  write enable.
- wb_cycle_i  in  1  bus cycle.
- wb_strobe_i  in  1  transfer strobe.
- wb_sel_i  in  1  byte select; access is ignored when 0, but still acked.
- wb_stall_o  out  1  constant 0.
- wb_ack_o  out  1  transfer acknowledge.
- col_sel_i  in  COL_SEL_WIDTH  CPU column select value (PIA port A).
- col_sel_we_i  in  1  one-cycle pulse when the CPU writes the column select.
- kbd_o  out  [COL_COUNT][ROW_COUNT]  matrix; 0 = pressed.

## Operation
Register map:
- 0x00..COL_COUNT-1: column register, R/W direct.
  - Out-of-range column addresses read 0xFF and ignore writes.
  - Read bits at or above ROW_COUNT return 1.
- 0x10 EVENT, write only; reads return 0.
  - Bit 7 = 1 release, 0 press.
  - Bits [6:3] = column; bits [2:0] = row.
- 0x11 STATUS.
  - Read: [7] overflow (sticky), [6] full, [5:0] count.
  - Writing any value with bit 7 = 1 clears overflow.
- 0x12 HOLD_SCANS, R/W, 8 bits.
- 0x13 CTRL, R/W.
  - [0] pause: when 1, no FIFO pops occur.
  - [1] flush: write 1 empties the FIFO; self-clearing, reads 0.
  - Other bits read 0.
- Other addresses: read 0x00, writes ignored.

Scan detection:
- A scan is counted on each col_sel_we_i pulse with col_sel_i == 0.

Event sequencer, 3 states:
- IDLE: if FIFO not empty and pause = 0, pop the head → APPLY.
- APPLY:
  - Write the addressed bit: press clears it, release sets it.
  - If a Wishbone column write targets the same column this cycle, stay in APPLY. The Wishbone write wins; the event is applied the next free cycle.
  - After applying, load scan_cnt = 0 → HOLD.
  - An event with column ≥ COL_COUNT or row ≥ ROW_COUNT is discarded, with no bit change and no hold → IDLE.
- HOLD:
  - scan_cnt increments on each detected scan.
  - When scan_cnt ≥ HOLD_SCANS → IDLE. With HOLD_SCANS = 0, HOLD lasts exactly 1 cycle.
  - A scan coinciding with the APPLY cycle is not counted.

FIFO:
- Push on an EVENT write.
- Push when full: the event is dropped and overflow is set. Count stays at FIFO_DEPTH.
- Simultaneous push and pop: count is unchanged, order preserved.
- Flush empties the FIFO, aborts nothing in progress (a HOLD in progress completes), and does not clear overflow.

Reset (asynchronous):
- kbd_o all 1.
- FIFO empty, overflow 0, state IDLE.
- HOLD_SCANS = HOLD_DEFAULT, CTRL = 0.
- wb_ack_o 0, wb_data_o 0.

## Timing
- Wishbone:
  - A strobe & cycle in cycle N is acked in N+1, with wb_data_o valid in N+1. Exactly one ack per strobe.
  - Back-to-back strobes are each acked.
- Direct column write in cycle N: kbd_o updates in N+1.
- EVENT write in cycle N with the sequencer idle and FIFO empty:
  - Entry visible in STATUS count in N+1.
  - Pop in N+1; kbd_o bit changes in N+2.
  - Count returns to 0 in N+2.
- The next event applies no earlier than HOLD_SCANS scans plus 2 cycles after the previous apply.
- pause written in cycle N takes effect from N+1. A pop already in APPLY completes.

## Test plan
- Reset, read all columns over Wishbone, read STATUS → every column 0xFF, STATUS 0x00, HOLD_SCANS 0x02.
- Write 0x50+col to every column, then read back over Wishbone and via kbd_o → values match. Rewrite 0xFF → all released.
- HOLD_SCANS = 2; push press(col 3, row 5) then release(col 3, row 5):
  - kbd_o[3][5] goes to 0 two cycles after the first push.
  - It stays 0 through 1 scan and returns to 1 only after the 2nd scan pulse plus 2 cycles.
- Push FIFO_DEPTH+1 events with pause = 1 → STATUS = 0xC8 (overflow, full, count 8). Write 0x80 → 0x48. Flush → 0x00.
- Event and Wishbone write to the same column in the same cycle → Wishbone value lands first; the event bit is applied one cycle later.
- Assert wb_reset_i mid-HOLD with 3 events queued → kbd_o all 1, count 0, IDLE. No event applies after reset is released.
